// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite ROM read path.
// Holds the RGB565 word, the return-tag layout and the behavioural ROM image.
package sprite_pkg;

    localparam int MAX_CH = 8;

    typedef logic [15:0] rgb565_t;

    localparam rgb565_t KEY_COLOR_DEF = 16'h0000;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    typedef struct packed {
        logic                      vld;
        logic [$clog2(MAX_CH)-1:0] ch;
        logic                      oob;
    } tag_t;

    // Built-in image used by the behavioural ROM when no image file is named;
    // every 37th word (offset 3) carries the transparent key.
    function automatic rgb565_t sim_rom_word(input logic [15:0] a);
        if (a % 16'd37 == 16'd3) return '0;
        return rgb565_t'((a * 16'd2654 + 16'd4097) ^ (a >> 3));
    endfunction

endpackage

// File: rtl/sprite_rom_bank.sv
// Single-port image ROM: EG_LOGIC_BRAM when USE_EG_BRAM is defined, otherwise a behavioural model.
// Latency 1 cycle (NOREG) or 2 cycles (OUTREG); always enabled, no backpressure.
module sprite_rom_bank
    import sprite_pkg::*;
#(
    parameter int    DATA_WIDTH = 16,
    parameter int    ADDR_WIDTH = 10,
    parameter int    DEPTH      = 990,
    parameter string REGMODE    = "NOREG",
    parameter string INIT_FILE  = "../mif/triangle.mif"
) (
    input  logic                  clka,
    input  logic [ADDR_WIDTH-1:0] addra,
    output logic [DATA_WIDTH-1:0] douta
);

`ifdef USE_EG_BRAM
    EG_LOGIC_BRAM #(
        .DATA_WIDTH_A (DATA_WIDTH),
        .ADDR_WIDTH_A (ADDR_WIDTH),
        .DATA_DEPTH_A (DEPTH),
        .DATA_WIDTH_B (DATA_WIDTH),
        .ADDR_WIDTH_B (ADDR_WIDTH),
        .DATA_DEPTH_B (DEPTH),
        .MODE         ("SP"),
        .REGMODE_A    (REGMODE),
        .RESETMODE    ("SYNC"),
        .IMPLEMENT    ("9K(FAST)"),
        .INIT_FILE    (INIT_FILE),
        .FILL_ALL     ("NONE")
    ) u_bram (
        .dia   ({DATA_WIDTH{1'b0}}),
        .dib   ({DATA_WIDTH{1'b0}}),
        .addra (addra),
        .addrb ({ADDR_WIDTH{1'b0}}),
        .cea   (1'b1),
        .ceb   (1'b0),
        .ocea  (1'b1),
        .oceb  (1'b0),
        .clka  (clka),
        .clkb  (1'b0),
        .wea   (1'b0),
        .web   (1'b0),
        .bea   (1'b0),
        .beb   (1'b0),
        .rsta  (1'b0),
        .rstb  (1'b0),
        .doa   (douta),
        .dob   ()
    );
`else
    // A named image cannot be loaded here, so it reads as all-zero; an empty name selects the built-in image.
    localparam bit                USE_PATTERN = (INIT_FILE == "");
    localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);

    logic                  in_range;
    logic [DATA_WIDTH-1:0] rd_q;

    assign in_range = ({1'b0, addra} < DEPTH_W);

    always_ff @(posedge clka) begin
        rd_q <= (USE_PATTERN && in_range) ? DATA_WIDTH'(sim_rom_word(16'(addra))) : '0;
    end

    if (REGMODE == "OUTREG") begin : g_outreg
        logic [DATA_WIDTH-1:0] out_q;
        always_ff @(posedge clka) begin
            out_q <= rd_q;
        end
        assign douta = out_q;
    end else begin : g_noreg
        assign douta = rd_q;
    end
`endif

endmodule

// File: rtl/sprite_rom_reader.sv
// Round-robin multi-channel read port onto one image ROM with range check and transparency flag.
// Latency 2+OUT_REG cycles gnt->rvalid, 1 read/cycle; no backpressure, requesters hold req until gnt.
module sprite_rom_reader
    import sprite_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DEPTH      = 990,
    parameter int                    NUM_CH     = 2,
    parameter int                    OUT_REG    = 0,
    parameter string                 INIT_FILE  = "../mif/triangle.mif",
    parameter logic [DATA_WIDTH-1:0] KEY_COLOR  = KEY_COLOR_DEF
) (
    input  logic                         clka,
    input  logic                         rsta_n,
    input  logic [NUM_CH-1:0]            req,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] addr,
    output logic [NUM_CH-1:0]            gnt,
    output logic [NUM_CH-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]        rdata,
    output logic                         rtransp,
    output logic                         err_oob
);

    localparam int LAT  = 2 + OUT_REG;
    localparam int CH_W = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
    localparam int TCW  = $clog2(MAX_CH);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    logic [1:0]            rst_sync_q;
    logic                  run;
    logic [CH_W-1:0]       rr_q;
    logic                  gnt_any;
    logic [CH_W-1:0]       gnt_idx;
    int                    cand;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_oob;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_dout;
    tag_t                  tag_d;
    tag_t                  tag_q [LAT];
    tag_t                  tag_ld;
    tag_t                  tag_out;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rtransp_q;

    // Release is taken through two flops so grants start on a clean edge.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) rst_sync_q <= '0;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign run = rst_sync_q[1];

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        gnt     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = int'(rr_q) + i;
            if (cand >= NUM_CH) cand = cand - NUM_CH;
            if (!gnt_any && run && req[CH_W'(cand)]) begin
                gnt_any = 1'b1;
                gnt_idx = CH_W'(cand);
            end
        end
        if (gnt_any) gnt[gnt_idx] = 1'b1;
    end

    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_idx == CH_W'(i)) sel_addr = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    assign sel_oob   = ({1'b0, sel_addr} >= DEPTH_W);
    assign bram_addr = (gnt_any && !sel_oob) ? sel_addr : '0;

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            rr_q <= '0;
        end else if (gnt_any) begin
            rr_q <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    sprite_rom_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .REGMODE    ((OUT_REG != 0) ? "OUTREG" : "NOREG"),
        .INIT_FILE  (INIT_FILE)
    ) u_bank (
        .clka  (clka),
        .addra (bram_addr),
        .douta (bram_dout)
    );

    assign tag_d = '{vld: gnt_any, ch: TCW'(gnt_idx), oob: gnt_any & sel_oob};

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= tag_d;
            for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    // tag_ld lines up with ROM data; tag_out is the cycle the word is presented.
    assign tag_ld  = tag_q[LAT-2];
    assign tag_out = tag_q[LAT-1];

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            rdata_q   <= '0;
            rtransp_q <= 1'b0;
        end else if (tag_ld.vld) begin
            rdata_q   <= tag_ld.oob ? '0 : bram_dout;
            rtransp_q <= !tag_ld.oob && (bram_dout == KEY_COLOR);
        end else begin
            rtransp_q <= 1'b0;
        end
    end

    always_comb begin
        rvalid = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rvalid[i] = tag_out.vld && (tag_out.ch == TCW'(i));
        end
    end

    assign rdata   = rdata_q;
    assign rtransp = rtransp_q;
    assign err_oob = tag_out.vld & tag_out.oob;

endmodule

// File: tb/tb_sprite_rom_reader.sv
// Bench for sprite_rom_reader: OUT_REG=0 and OUT_REG=1 instances share stimulus;
// each return is matched against a per-instance queue of expected words.
module tb_sprite_rom_reader;

    typedef struct {
        int          ch;
        logic [15:0] dat;
        logic        oob;
        logic        tr;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [19:0] addr;
    logic [1:0]  gnt0, gnt1, rv0, rv1;
    logic [15:0] rd0, rd1;
    logic        tr0, tr1, oob0, oob1;

    int   total = 0;
    int   bad   = 0;
    int   ec    = 0;
    int   ptr   = 0;
    bit   allow = 1'b0;
    exp_t q0[$];
    exp_t q1[$];

    sprite_rom_reader #(
        .DATA_WIDTH(16), .ADDR_WIDTH(10), .DEPTH(990), .NUM_CH(2), .OUT_REG(0),
        .INIT_FILE(""), .KEY_COLOR(16'h0000)
    ) dut0 (
        .clka(clk), .rsta_n(rst_n), .req(req), .addr(addr), .gnt(gnt0),
        .rvalid(rv0), .rdata(rd0), .rtransp(tr0), .err_oob(oob0)
    );

    sprite_rom_reader #(
        .DATA_WIDTH(16), .ADDR_WIDTH(10), .DEPTH(990), .NUM_CH(2), .OUT_REG(1),
        .INIT_FILE(""), .KEY_COLOR(16'h0000)
    ) dut1 (
        .clka(clk), .rsta_n(rst_n), .req(req), .addr(addr), .gnt(gnt1),
        .rvalid(rv1), .rdata(rd1), .rtransp(tr1), .err_oob(oob1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ec++;

    // ROM image as seen by a reader: words past DEPTH read as zero.
    function automatic logic [15:0] img(input int a);
        if (a >= 990) return 16'h0000;
        if (a % 37 == 3) return 16'h0000;
        return 16'((a * 2654 + 4097) ^ (a >> 3));
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %h want %h (edge %0d)", nm, d, act, exp, ec);
        end
    endtask

    task automatic push(input int k, input int a);
        exp_t e;
        e.ch  = k;
        e.oob = (a >= 990);
        e.dat = img(a);
        e.tr  = !e.oob && (e.dat == 16'h0000);
        e.due = ec + 2;
        q0.push_back(e);
        e.due = ec + 3;
        q1.push_back(e);
    endtask

    task automatic mon(input int d, input logic [1:0] rv, input logic [15:0] rd,
                       input logic tr, input logic ob);
        exp_t e;
        int   n;
        n = (d == 0) ? q0.size() : q1.size();
        if (rv != 2'b00) begin
            if (n == 0) begin
                chk("unexpected_rvalid", d, 32'(rv), 32'h0);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk("rvalid", d, 32'(rv), 32'(1 << e.ch));
                chk("rdata", d, 32'(rd), 32'(e.dat));
                chk("rtransp", d, 32'(tr), 32'(e.tr));
                chk("err_oob", d, 32'(ob), 32'(e.oob));
                chk("latency_edge", d, ec, e.due);
            end
        end else begin
            chk("idle_rtransp", d, 32'(tr), 32'h0);
            chk("idle_err_oob", d, 32'(ob), 32'h0);
            if (n > 0) begin
                if (d == 0) e = q0[0];
                else        e = q1[0];
                if (e.due <= ec) begin
                    chk("missing_return", d, ec, e.due);
                    if (d == 0) void'(q0.pop_front());
                    else        void'(q1.pop_front());
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, rv0, rd0, tr0, oob0);
        mon(1, rv1, rd1, tr1, oob1);
    end

    // One cycle of stimulus; the expected grant comes from the round-robin rule.
    task automatic drive(input int r, input int a0, input int a1);
        int k;
        int c;
        logic [1:0] exp_g;
        @(negedge clk);
        req  = 2'(r);
        addr = {10'(a1), 10'(a0)};
        #1;
        k = -1;
        if (allow) begin
            for (int i = 0; i < 2; i++) begin
                c = (ptr + i) % 2;
                if (k < 0 && req[c]) k = c;
            end
        end
        exp_g = (k >= 0) ? 2'(1 << k) : 2'b00;
        chk("gnt", 0, 32'(gnt0), 32'(exp_g));
        chk("gnt", 1, 32'(gnt1), 32'(exp_g));
        if (k >= 0) begin
            push(k, (k == 1) ? a1 : a0);
            ptr = (k + 1) % 2;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 2'b11;
        addr  = {10'd20, 10'd10};
        q0.delete();
        q1.delete();
        ptr   = 0;
        allow = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("rst_gnt", 0, 32'(gnt0), 32'h0);
            chk("rst_gnt", 1, 32'(gnt1), 32'h0);
            chk("rst_rvalid", 0, 32'(rv0), 32'h0);
            chk("rst_rvalid", 1, 32'(rv1), 32'h0);
            chk("rst_rdata", 0, 32'(rd0), 32'h0);
            chk("rst_rdata", 1, 32'(rd1), 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_gnt", 0, 32'(gnt0), 32'h0);
        chk("release_gnt", 1, 32'(gnt1), 32'h0);
        drive(0, 0, 0);
        allow = 1'b1;
    endtask

    function automatic int pick_addr();
        case ($urandom_range(0, 5))
            0:       return 989;
            1:       return 990;
            2:       return 1023;
            3:       return 3;
            default: return int'($urandom_range(0, 1023));
        endcase
    endfunction

    initial begin
        rst_n = 1'b1;
        req   = 2'b00;
        addr  = '0;
        #1;
        rst_n = 1'b0;
        do_reset();

        drive(1, 5, 0);
        idle(4);
        drive(2, 0, 7);
        idle(4);

        for (int i = 0; i < 6; i++) drive(3, 10, 20);
        idle(4);

        drive(1, 989, 0);
        drive(2, 0, 990);
        drive(1, 1023, 0);
        idle(4);

        drive(1, 3, 0);
        drive(2, 0, 5);
        idle(4);

        drive(1, 5, 0);
        do_reset();
        drive(3, 10, 20);
        idle(4);

        for (int i = 0; i < 400; i++) begin
            drive(int'($urandom_range(0, 3)), pick_addr(), pick_addr());
        end
        idle(6);

        chk("drain_queue", 0, q0.size(), 0);
        chk("drain_queue", 1, q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish by %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
